// File: rtl/exc_ctrl_if.sv
// Decode-stage trap sequencer bus: pipeline-side requests in, redirect/kill/EPC controls out.
// The pipeline is the master; exc_ctrl is the slave.
interface exc_ctrl_if;
    logic        Interrupt;
    logic        Exception;
    logic        IDValid;
    logic        IDStall;
    logic        IDCtrlXfer;
    logic        ERetID;
    logic [31:0] IDPC;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        FlushIFID;
    logic        KillID;
    logic        EPCWrite;
    logic [31:0] EPCData;
    logic        KernelMode;
    logic        IntPending;

    modport master (
        output Interrupt, Exception, IDValid, IDStall, IDCtrlXfer, ERetID, IDPC,
        input  Redirect, RedirectPC, FlushIFID, KillID, EPCWrite, EPCData,
               KernelMode, IntPending
    );

    modport slave (
        input  Interrupt, Exception, IDValid, IDStall, IDCtrlXfer, ERetID, IDPC,
        output Redirect, RedirectPC, FlushIFID, KillID, EPCWrite, EPCData,
               KernelMode, IntPending
    );
endinterface

// File: rtl/exc_ctrl.sv
// Trap sequencer: arbitrates exception / eret / interrupt in ID and kills the ID slot.
// Optional IRQ_SYNC_EN adds a two-flop synchronizer in front of the interrupt pending latch.
module exc_ctrl #(
    parameter logic [31:0] INT_VEC      = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC      = 32'h8000_0008,
    parameter int unsigned REARM_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    exc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_KERNEL = 2'd1,
        ST_REARM  = 2'd2
    } state_t;

    localparam logic [3:0] REARM_INIT = 4'(REARM_CYCLES);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        pend_r;
    logic        pend_s;
    logic        kernel_r;
    logic        irq_s;
    logic        eligible_s;
    logic        exc_acc_s;
    logic        eret_acc_s;
    logic        int_acc_s;
    logic        accept_s;
    logic [31:0] redirect_pc_s;
    logic [31:0] epc_data_s;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for an interrupt line asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], bus.Interrupt};
        end
    end

    assign irq_s = sync_r[1];
`else
    assign irq_s = bus.Interrupt;
`endif

    // Accept decisions; reset gates everything so no kill leaks out while in reset.
    always_comb begin
        eligible_s = bus.IDValid & ~bus.IDStall & ~reset;
        exc_acc_s  = eligible_s & bus.Exception;
        eret_acc_s = eligible_s & bus.ERetID & ~bus.Exception & (state_r == ST_KERNEL);
        int_acc_s  = eligible_s & pend_r & (state_r == ST_RUN) & ~bus.IDCtrlXfer
                     & ~bus.Exception & ~bus.ERetID;
        accept_s   = exc_acc_s | int_acc_s;
    end

    // Next state, rearm counter and pending latch.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pend_s  = irq_s | (pend_r & ~int_acc_s);
        case (state_r)
            ST_RUN: begin
                if (accept_s) begin
                    state_s = ST_KERNEL;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_KERNEL: begin
                if (exc_acc_s) begin
                    state_s = ST_KERNEL;
                end else if (eret_acc_s) begin
                    state_s = ST_REARM;
                    cnt_s   = REARM_INIT;
                end else begin
                    state_s = ST_KERNEL;
                end
            end
            ST_REARM: begin
                if (exc_acc_s) begin
                    state_s = ST_KERNEL;
                    cnt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    // Leaving on the count that reads 1 gives exactly REARM_CYCLES blocked cycles.
                    state_s = ST_RUN;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Redirect target and EPC value for the accepting cycle, zero otherwise.
    always_comb begin
        redirect_pc_s = 32'h0000_0000;
        epc_data_s    = 32'h0000_0000;
        if (exc_acc_s) begin
            redirect_pc_s = EXC_VEC;
            epc_data_s    = bus.IDPC + 32'd4;
        end else if (int_acc_s) begin
            redirect_pc_s = INT_VEC;
            epc_data_s    = bus.IDPC;
        end else begin
            redirect_pc_s = 32'h0000_0000;
            epc_data_s    = 32'h0000_0000;
        end
    end

    // State, counter, pending latch and kernel-mode flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_RUN;
            cnt_r    <= 4'd0;
            pend_r   <= 1'b0;
            kernel_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            pend_r   <= pend_s;
            kernel_r <= (state_s == ST_KERNEL);
        end
    end

    assign bus.Redirect   = accept_s;
    assign bus.FlushIFID  = accept_s;
    assign bus.KillID     = accept_s;
    assign bus.EPCWrite   = accept_s;
    assign bus.RedirectPC = redirect_pc_s;
    assign bus.EPCData    = epc_data_s;
    assign bus.KernelMode = kernel_r;
    assign bus.IntPending = pend_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: interrupt/exception/eret arbitration, rearm window, stall, reset.
module tb_exc_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    exc_ctrl_if bus ();

    exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic x,
                         input logic e, input logic r, input logic [31:0] pc);
        bus.IDValid    = v;
        bus.IDStall    = s;
        bus.IDCtrlXfer = x;
        bus.Exception  = e;
        bus.ERetID     = r;
        bus.IDPC       = pc;
    endtask

    task automatic do_reset();
        bus.Interrupt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Interrupt = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000);
        step();
        #1;
        checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got=%0b exp=0", bus.Redirect); end
        checks++; if (bus.KillID !== 1'b0) begin errors++; $display("FAIL rst_kill got=%0b exp=0", bus.KillID); end
        checks++; if (bus.KernelMode !== 1'b0) begin errors++; $display("FAIL rst_kernel got=%0b exp=0", bus.KernelMode); end
        checks++; if (bus.IntPending !== 1'b0) begin errors++; $display("FAIL rst_pend got=%0b exp=0", bus.IntPending); end
        checks++; if (bus.EPCData !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=0", bus.EPCData); end
        do_reset();
    endtask

    task automatic test_int_accept();
        do_reset();
        bus.Interrupt = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL int_bubble got=%0b exp=0", bus.Redirect); end
        step();
        bus.Interrupt = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0010);
        #1;
        checks++; if (bus.IntPending !== 1'b1) begin errors++; $display("FAIL int_pend_set got=%0b exp=1", bus.IntPending); end
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL int_redirect got=%0b exp=1", bus.Redirect); end
        checks++; if (bus.RedirectPC !== 32'h8000_0004) begin errors++; $display("FAIL int_vec got=%h exp=80000004", bus.RedirectPC); end
        checks++; if (bus.EPCData !== 32'h0040_0010) begin errors++; $display("FAIL int_epc got=%h exp=00400010", bus.EPCData); end
        checks++; if ({bus.KillID, bus.FlushIFID, bus.EPCWrite} !== 3'b111) begin errors++; $display("FAIL int_kill got=%b exp=111", {bus.KillID, bus.FlushIFID, bus.EPCWrite}); end
        checks++; if (bus.KernelMode !== 1'b0) begin errors++; $display("FAIL int_kernel_early got=%0b exp=0", bus.KernelMode); end
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.KernelMode !== 1'b1) begin errors++; $display("FAIL int_kernel got=%0b exp=1", bus.KernelMode); end
        checks++; if (bus.IntPending !== 1'b0) begin errors++; $display("FAIL int_pend_clr got=%0b exp=0", bus.IntPending); end
        checks++; if (bus.Redirect !== 1'b0 || bus.RedirectPC !== 32'h0) begin errors++; $display("FAIL int_one_cycle got=%0b/%h exp=0/0", bus.Redirect, bus.RedirectPC); end
    endtask

    task automatic test_exception();
        do_reset();
        bus.Interrupt = 1'b1;
        step();
        bus.Interrupt = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0020);
        #1;
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL exc_redirect got=%0b exp=1", bus.Redirect); end
        checks++; if (bus.RedirectPC !== 32'h8000_0008) begin errors++; $display("FAIL exc_vec got=%h exp=80000008", bus.RedirectPC); end
        checks++; if (bus.EPCData !== 32'h0040_0024) begin errors++; $display("FAIL exc_epc got=%h exp=00400024", bus.EPCData); end
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0100);
        #1;
        checks++; if (bus.IntPending !== 1'b1) begin errors++; $display("FAIL exc_pend_keep got=%0b exp=1", bus.IntPending); end
        checks++; if (bus.KernelMode !== 1'b1) begin errors++; $display("FAIL exc_kernel got=%0b exp=1", bus.KernelMode); end
        checks++; if (bus.EPCData !== 32'h0040_0104) begin errors++; $display("FAIL exc_nested_epc got=%h exp=00400104", bus.EPCData); end
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010);
        #1;
        checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL exc_no_int_in_kernel got=%0b exp=0", bus.Redirect); end
        checks++; if (bus.KernelMode !== 1'b1) begin errors++; $display("FAIL exc_kernel_stay got=%0b exp=1", bus.KernelMode); end
    endtask

    task automatic test_ctrl_xfer();
        do_reset();
        bus.Interrupt = 1'b1;
        step();
        bus.Interrupt = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_002C);
        #1;
        checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL xfer_defer got=%0b exp=0", bus.Redirect); end
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0030);
        #1;
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL xfer_accept got=%0b exp=1", bus.Redirect); end
        checks++; if (bus.EPCData !== 32'h0040_0030) begin errors++; $display("FAIL xfer_epc got=%h exp=00400030", bus.EPCData); end
    endtask

    task automatic test_eret_rearm();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000);
        step();
        bus.Interrupt = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0020);
        #1;
        checks++; if (bus.Redirect !== 1'b0 || bus.KillID !== 1'b0) begin errors++; $display("FAIL eret_no_kill got=%0b/%0b exp=0/0", bus.Redirect, bus.KillID); end
        for (int i = 0; i < 2; i++) begin
            step();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040);
            #1;
            checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL rearm_block%0d got=%0b exp=0", i, bus.Redirect); end
            checks++; if (bus.KernelMode !== 1'b0) begin errors++; $display("FAIL rearm_kernel%0d got=%0b exp=0", i, bus.KernelMode); end
        end
        step();
        #1;
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL rearm_accept got=%0b exp=1", bus.Redirect); end
        checks++; if (bus.EPCData !== 32'h0040_0040) begin errors++; $display("FAIL rearm_epc got=%h exp=00400040", bus.EPCData); end
        step();
        bus.Interrupt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.IntPending !== 1'b1) begin errors++; $display("FAIL pend_held_level got=%0b exp=1", bus.IntPending); end
    endtask

    task automatic test_exc_in_rearm();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0020);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0050);
        #1;
        checks++; if (bus.EPCData !== 32'h0040_0054) begin errors++; $display("FAIL rearm_exc_epc got=%h exp=00400054", bus.EPCData); end
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.KernelMode !== 1'b1) begin errors++; $display("FAIL rearm_exc_kernel got=%0b exp=1", bus.KernelMode); end
    endtask

    task automatic test_eret_ignored();
        do_reset();
        bus.Interrupt = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0060);
        #1;
        checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL eret_user got=%0b exp=0", bus.Redirect); end
        step();
        bus.Interrupt = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0064);
        #1;
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL eret_user_no_rearm got=%0b exp=1", bus.Redirect); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.Interrupt = 1'b1;
        step();
        bus.Interrupt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0070);
            #1;
            checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL stall_block%0d got=%0b exp=0", i, bus.Redirect); end
            checks++; if (bus.IntPending !== 1'b1) begin errors++; $display("FAIL stall_pend%0d got=%0b exp=1", i, bus.IntPending); end
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0070);
        #1;
        checks++; if (bus.Redirect !== 1'b1) begin errors++; $display("FAIL stall_release got=%0b exp=1", bus.Redirect); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.Interrupt = 1'b1;
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0080);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if ({bus.KernelMode, bus.IntPending} !== 2'b11) begin errors++; $display("FAIL arst_pre got=%b exp=11", {bus.KernelMode, bus.IntPending}); end
        bus.Interrupt = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.KernelMode !== 1'b0) begin errors++; $display("FAIL arst_kernel got=%0b exp=0", bus.KernelMode); end
        checks++; if (bus.IntPending !== 1'b0) begin errors++; $display("FAIL arst_pend got=%0b exp=0", bus.IntPending); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0090 + 32'(4 * i));
            #1;
            checks++; if (bus.Redirect !== 1'b0) begin errors++; $display("FAIL arst_no_redirect%0d got=%0b exp=0", i, bus.Redirect); end
            step();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.Interrupt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_int_accept();
        test_exception();
        test_ctrl_xfer();
        test_eret_rearm();
        test_exc_in_rearm();
        test_eret_ignored();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
